// File: rtl/pipe_rf_pkg.sv
// Shared widths, the hard-wired zero register index and the register index type
// for the pipeline register file.
`default_nettype none

package pipe_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/pipe_reg_file_sb_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, a running count of busy
// registers, and per-read-port busy flags that already account for this cycle's write-back.
`default_nettype none

module reg_scoreboard
  import pipe_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic             set_ok;
  logic             clr_ok;
  logic             inc;
  logic             dec;

  always_comb begin
    set_ok = rsv_en && !(ZERO_REG && rsv_addr == ADDR_W'(REG_ZERO));
    clr_ok = wr_en  && !(ZERO_REG && wr_addr  == ADDR_W'(REG_ZERO));
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_mask[i] = set_ok && (rsv_addr == ADDR_W'(i));
      clr_mask[i] = clr_ok && (wr_addr  == ADDR_W'(i));
    end
    // A same-index set/clear keeps the bit, so neither edge of the count moves.
    inc = set_ok && !busy[rsv_addr];
    dec = clr_ok && busy[wr_addr] && !(set_ok && rsv_addr == wr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      case ({inc, dec})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  assign rd_busy1 = busy[rd_addr1] &
                    ~(wr_en & (wr_addr == rd_addr1) & ~(rsv_en & (rsv_addr == rd_addr1)));
  assign rd_busy2 = busy[rd_addr2] &
                    ~(wr_en & (wr_addr == rd_addr2) & ~(rsv_en & (rsv_addr == rd_addr2)));

endmodule

`default_nettype wire

// File: rtl/pipe_reg_file_sb.sv
// 2-read/1-write register file with write-to-read bypass and an integrated
// scoreboard of pending destination registers.
`default_nettype none

module pipe_reg_file_sb
  import pipe_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_next1;
  logic [DATA_W-1:0] rd_next2;
  logic              wr_ok;

  always_comb begin
    wr_ok = wr_en && !(ZERO_REG && wr_addr == ADDR_W'(REG_ZERO));

    if (ZERO_REG && rd_addr1 == ADDR_W'(REG_ZERO))
      rd_next1 = '0;
    else if (wr_en && wr_addr == rd_addr1)
      rd_next1 = wr_data;
    else
      rd_next1 = regs[rd_addr1];

    if (ZERO_REG && rd_addr2 == ADDR_W'(REG_ZERO))
      rd_next2 = '0;
    else if (wr_en && wr_addr == rd_addr2)
      rd_next2 = wr_data;
    else
      rd_next2 = regs[rd_addr2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      rd_data1 <= rd_next1;
      rd_data2 <= rd_next2;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2),
    .pend_cnt (pend_cnt)
  );

endmodule

`default_nettype wire
